// File: rtl/mem_port_arbiter.sv
// Shares one RAM port between instruction fetch and load/store: arbitrate, issue a
// one-cycle command, then capture read data and return it to the requester that won.
module mem_port_arbiter #(
  parameter int DATA_WIDTH   = 32,
  parameter int RAM_WIDTH    = 31,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_req,
  input  logic [RAM_WIDTH-1:0]  if_addr,
  output logic                  if_ack,
  output logic                  if_rvalid,
  output logic [DATA_WIDTH-1:0] if_rdata,
  input  logic                  dm_req,
  input  logic                  dm_we,
  input  logic [RAM_WIDTH-1:0]  dm_addr,
  input  logic [3:0]            dm_be,
  input  logic [DATA_WIDTH-1:0] dm_wdata,
  output logic                  dm_ack,
  output logic                  dm_rvalid,
  output logic [DATA_WIDTH-1:0] dm_rdata,
  output logic                  ram_en,
  output logic                  ram_we,
  output logic [3:0]            ram_be,
  output logic [RAM_WIDTH-1:0]  ram_addr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  input  logic [DATA_WIDTH-1:0] ram_rdata,
  output logic                  busy
);

  // state | meaning
  // ARB   | sample requests, pick a winner, register its RAM command
  // CMD   | command on the RAM port, winner's ack high
  // RESP  | RAM read data valid, captured at the closing edge
  typedef enum logic [1:0] {ARB, CMD, RESP} state_t;
  typedef enum logic [1:0] {SEL_NONE, SEL_IF, SEL_DM} sel_t;

  localparam logic [3:0]           LIMIT     = 4'(STARVE_LIMIT);
  localparam logic [RAM_WIDTH-1:0] WORD_MASK = ~RAM_WIDTH'(3);

  state_t     state, state_next;
  sel_t       grant_sel, grant_sel_next;
  logic [3:0] streak, streak_next;
  logic       grant_if, grant_dm;

  assign busy = (state != ARB);

  always_comb begin
    state_next     = state;
    grant_sel_next = grant_sel;
    streak_next    = streak;
    grant_if       = 1'b0;
    grant_dm       = 1'b0;
    case (state)
      ARB: begin
        // Fetch wins a contested cycle only once the data streak has hit the limit.
        if (dm_req && !(if_req && streak == LIMIT)) grant_dm = 1'b1;
        else if (if_req)                            grant_if = 1'b1;

        if (!if_req)               streak_next = 4'd0;
        else if (grant_if)         streak_next = 4'd0;
        else if (streak != LIMIT)  streak_next = streak + 4'd1;

        if (grant_dm) begin
          state_next     = CMD;
          grant_sel_next = SEL_DM;
        end else if (grant_if) begin
          state_next     = CMD;
          grant_sel_next = SEL_IF;
        end else begin
          grant_sel_next = SEL_NONE;
        end
      end
      CMD:     state_next = ram_we ? ARB : RESP;
      RESP:    state_next = ARB;
      default: state_next = ARB;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ARB;
      grant_sel <= SEL_NONE;
      streak    <= 4'd0;
      if_ack    <= 1'b0;
      dm_ack    <= 1'b0;
      if_rvalid <= 1'b0;
      dm_rvalid <= 1'b0;
      if_rdata  <= '0;
      dm_rdata  <= '0;
      ram_en    <= 1'b0;
      ram_we    <= 1'b0;
      ram_be    <= 4'h0;
      ram_addr  <= '0;
      ram_wdata <= '0;
    end else begin
      state     <= state_next;
      grant_sel <= grant_sel_next;
      streak    <= streak_next;

      // Command fields live for exactly the CMD cycle and read as zero otherwise.
      if_ack    <= grant_if;
      dm_ack    <= grant_dm;
      ram_en    <= grant_if | grant_dm;
      ram_we    <= grant_dm & dm_we;
      ram_be    <= (grant_dm && dm_we) ? dm_be : ((grant_if || grant_dm) ? 4'hF : 4'h0);
      ram_addr  <= grant_dm ? (dm_addr & WORD_MASK) :
                   (grant_if ? (if_addr & WORD_MASK) : '0);
      ram_wdata <= (grant_dm && dm_we) ? dm_wdata : '0;

      if_rvalid <= (state == RESP) && (grant_sel == SEL_IF);
      dm_rvalid <= (state == RESP) && (grant_sel == SEL_DM);
      if ((state == RESP) && (grant_sel == SEL_IF)) if_rdata <= ram_rdata;
      if ((state == RESP) && (grant_sel == SEL_DM)) dm_rdata <= ram_rdata;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: a behavioural RAM, a read-data scoreboard
// and one task per scenario.
module tb_mem_port_arbiter;

  logic        clk;
  logic        rst;
  logic        if_req;
  logic [30:0] if_addr;
  logic        if_ack;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        dm_req;
  logic        dm_we;
  logic [30:0] dm_addr;
  logic [3:0]  dm_be;
  logic [31:0] dm_wdata;
  logic        dm_ack;
  logic        dm_rvalid;
  logic [31:0] dm_rdata;
  logic        ram_en;
  logic        ram_we;
  logic [3:0]  ram_be;
  logic [30:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;
  logic        busy;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic        is_dm;
    logic [31:0] data;
  } exp_t;
  exp_t exp_q[$];

  logic [31:0] mem [logic [30:0]];

  mem_port_arbiter #(.DATA_WIDTH(32), .RAM_WIDTH(31), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_be(dm_be),
    .dm_wdata(dm_wdata), .dm_ack(dm_ack), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
    .ram_en(ram_en), .ram_we(ram_we), .ram_be(ram_be), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_val(input logic [30:0] a);
    if (mem.exists(a)) return mem[a];
    return {a[29:0], 2'b01} ^ 32'hC3C3_0000;
  endfunction

  // RAM model: read data valid the cycle after a read command.
  always @(posedge clk) begin
    logic [31:0] w;
    if (ram_en && ram_we) begin
      w = mem_val(ram_addr);
      for (int b = 0; b < 4; b++)
        if (ram_be[b]) w[8*b +: 8] = ram_wdata[8*b +: 8];
      mem[ram_addr] = w;
    end
    if (ram_en && !ram_we) ram_rdata <= mem_val(ram_addr);
  end

  // Scoreboard: every rvalid pops the oldest expected read.
  exp_t        sb_e;
  logic [31:0] sb_got;
  always @(negedge clk) begin
    if (if_rvalid || dm_rvalid) begin
      checks++;
      if (if_rvalid && dm_rvalid) begin
        failures++;
        $display("FAIL dual_rvalid if_rvalid=%b dm_rvalid=%b required one-hot", if_rvalid, dm_rvalid);
      end else if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_rvalid if_rvalid=%b dm_rvalid=%b required none pending", if_rvalid, dm_rvalid);
      end else begin
        sb_e   = exp_q.pop_front();
        sb_got = dm_rvalid ? dm_rdata : if_rdata;
        if (dm_rvalid !== sb_e.is_dm || sb_got !== sb_e.data) begin
          failures++;
          $display("FAIL rdata_scoreboard got is_dm=%b data=%h required is_dm=%b data=%h",
                   dm_rvalid, sb_got, sb_e.is_dm, sb_e.data);
        end
      end
    end
    if (if_ack || dm_ack) begin
      checks++;
      if (if_ack && dm_ack) begin
        failures++;
        $display("FAIL dual_ack if_ack=%b dm_ack=%b required one-hot", if_ack, dm_ack);
      end
    end
  end

  task automatic test_reset;
    rst = 1'b1;
    if_req = 0; if_addr = '0; dm_req = 0; dm_we = 0; dm_addr = '0; dm_be = '0; dm_wdata = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({if_ack, if_rvalid, dm_ack, dm_rvalid, ram_en, ram_we, busy} !== 7'b0) begin
      failures++;
      $display("FAIL reset_flags got %b required 0000000",
               {if_ack, if_rvalid, dm_ack, dm_rvalid, ram_en, ram_we, busy});
    end
    checks++;
    if (ram_addr !== 31'h0 || ram_be !== 4'h0 || ram_wdata !== 32'h0) begin
      failures++;
      $display("FAIL reset_ram got addr=%h be=%h wdata=%h required 0", ram_addr, ram_be, ram_wdata);
    end
    checks++;
    if (if_rdata !== 32'h0 || dm_rdata !== 32'h0) begin
      failures++;
      $display("FAIL reset_rdata got if=%h dm=%h required 0", if_rdata, dm_rdata);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_fetch_read;
    mem[31'h10] = 32'hDEADBEEF;
    if_req = 1; if_addr = 31'h10;
    exp_q.push_back('{is_dm: 1'b0, data: 32'hDEADBEEF});
    @(negedge clk);
    checks++;
    if (if_ack !== 1'b1 || dm_ack !== 1'b0 || ram_en !== 1'b1 || ram_we !== 1'b0) begin
      failures++;
      $display("FAIL fetch_cmd got if_ack=%b dm_ack=%b ram_en=%b ram_we=%b required 1 0 1 0",
               if_ack, dm_ack, ram_en, ram_we);
    end
    checks++;
    if (ram_addr !== 31'h10 || ram_be !== 4'hF) begin
      failures++;
      $display("FAIL fetch_addr got addr=%h be=%h required 10 f", ram_addr, ram_be);
    end
    if_req = 0;
    @(negedge clk);
    checks++;
    if (ram_en !== 1'b0 || if_ack !== 1'b0 || busy !== 1'b1 || if_rvalid !== 1'b0) begin
      failures++;
      $display("FAIL fetch_resp got ram_en=%b if_ack=%b busy=%b if_rvalid=%b required 0 0 1 0",
               ram_en, if_ack, busy, if_rvalid);
    end
    @(negedge clk);
    checks++;
    if (if_rvalid !== 1'b1 || if_rdata !== 32'hDEADBEEF || busy !== 1'b0) begin
      failures++;
      $display("FAIL fetch_rvalid got rvalid=%b rdata=%h busy=%b required 1 deadbeef 0",
               if_rvalid, if_rdata, busy);
    end
    @(negedge clk);
    checks++;
    if (if_rvalid !== 1'b0 || if_rdata !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL fetch_hold got rvalid=%b rdata=%h required 0 deadbeef", if_rvalid, if_rdata);
    end
  endtask

  task automatic test_store;
    dm_req = 1; dm_we = 1; dm_addr = 31'h23; dm_be = 4'b0011; dm_wdata = 32'h0000ABCD;
    @(negedge clk);
    checks++;
    if (dm_ack !== 1'b1 || ram_en !== 1'b1 || ram_we !== 1'b1) begin
      failures++;
      $display("FAIL store_cmd got dm_ack=%b ram_en=%b ram_we=%b required 1 1 1", dm_ack, ram_en, ram_we);
    end
    checks++;
    if (ram_addr !== 31'h20 || ram_be !== 4'b0011 || ram_wdata !== 32'h0000ABCD) begin
      failures++;
      $display("FAIL store_fields got addr=%h be=%b wdata=%h required 20 0011 0000abcd",
               ram_addr, ram_be, ram_wdata);
    end
    dm_req = 0; dm_we = 0;
    @(negedge clk);
    checks++;
    if (ram_we !== 1'b0 || ram_en !== 1'b0 || busy !== 1'b0 || dm_ack !== 1'b0) begin
      failures++;
      $display("FAIL store_done got ram_we=%b ram_en=%b busy=%b dm_ack=%b required 0 0 0 0",
               ram_we, ram_en, busy, dm_ack);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (mem_val(31'h20) !== {mem_val(31'h20) & 32'hFFFF_0000 | 32'h0000ABCD}) begin
      failures++;
      $display("FAIL store_mem got %h required low half abcd", mem_val(31'h20));
    end
  endtask

  task automatic test_back_to_back;
    dm_req = 1; dm_we = 1; dm_addr = 31'h40; dm_be = 4'hF; dm_wdata = 32'hCAFE0123;
    @(negedge clk);
    checks++;
    if (dm_ack !== 1'b1 || ram_we !== 1'b1) begin
      failures++;
      $display("FAIL b2b_store got dm_ack=%b ram_we=%b required 1 1", dm_ack, ram_we);
    end
    dm_we = 0; dm_wdata = 32'h0;
    exp_q.push_back('{is_dm: 1'b1, data: 32'hCAFE0123});
    @(negedge clk);
    checks++;
    if (dm_ack !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL b2b_gap got dm_ack=%b busy=%b required 0 0", dm_ack, busy);
    end
    @(negedge clk);
    checks++;
    if (dm_ack !== 1'b1 || ram_we !== 1'b0 || ram_addr !== 31'h40 || ram_be !== 4'hF) begin
      failures++;
      $display("FAIL b2b_load got dm_ack=%b ram_we=%b addr=%h be=%h required 1 0 40 f",
               dm_ack, ram_we, ram_addr, ram_be);
    end
    dm_req = 0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_starvation;
    bit grant_q[$];
    bit exp_dm;
    int acks = 0;
    for (int i = 0; i < 10; i++) grant_q.push_back(!(i == 4 || i == 9));
    if_req = 1; if_addr = 31'h200; dm_req = 1; dm_we = 0; dm_addr = 31'h100;
    for (int c = 0; c < 45; c++) begin
      @(negedge clk);
      if (if_ack || dm_ack) begin
        checks++;
        if (grant_q.size() == 0) begin
          failures++;
          $display("FAIL starve_extra_grant got if_ack=%b dm_ack=%b required no grant", if_ack, dm_ack);
        end else begin
          exp_dm = grant_q.pop_front();
          if (dm_ack !== exp_dm) begin
            failures++;
            $display("FAIL starve_order grant=%0d got dm_ack=%b required %b", acks, dm_ack, exp_dm);
          end
          exp_q.push_back('{is_dm: exp_dm, data: exp_dm ? mem_val(31'h100) : mem_val(31'h200)});
        end
        acks++;
        if (acks == 10) begin if_req = 0; dm_req = 0; end
      end
    end
    checks++;
    if (acks !== 10) begin
      failures++;
      $display("FAIL starve_count got %0d required 10", acks);
    end
  endtask

  task automatic test_streak_clear;
    bit grant_q[$];
    bit exp_dm;
    int acks = 0;
    for (int i = 0; i < 10; i++) grant_q.push_back(i != 9);
    if_req = 1; if_addr = 31'h304; dm_req = 1; dm_we = 0; dm_addr = 31'h408;
    for (int c = 0; c < 45; c++) begin
      @(negedge clk);
      if (if_ack || dm_ack) begin
        checks++;
        if (grant_q.size() == 0) begin
          failures++;
          $display("FAIL streak_extra_grant got if_ack=%b dm_ack=%b required no grant", if_ack, dm_ack);
        end else begin
          exp_dm = grant_q.pop_front();
          if (dm_ack !== exp_dm) begin
            failures++;
            $display("FAIL streak_order grant=%0d got dm_ack=%b required %b", acks, dm_ack, exp_dm);
          end
          exp_q.push_back('{is_dm: exp_dm, data: exp_dm ? mem_val(31'h408) : mem_val(31'h304)});
        end
        acks++;
        if (acks == 4) if_req = 0;
        if (acks == 5) if_req = 1;
        if (acks == 10) begin if_req = 0; dm_req = 0; end
      end
    end
    checks++;
    if (acks !== 10) begin
      failures++;
      $display("FAIL streak_count got %0d required 10", acks);
    end
  endtask

  task automatic test_reset_mid_cmd;
    dm_req = 1; dm_we = 0; dm_addr = 31'h80;
    @(negedge clk);
    checks++;
    if (dm_ack !== 1'b1 || busy !== 1'b1) begin
      failures++;
      $display("FAIL abort_cmd got dm_ack=%b busy=%b required 1 1", dm_ack, busy);
    end
    dm_req = 0; rst = 1;
    @(negedge clk);
    checks++;
    if ({if_ack, if_rvalid, dm_ack, dm_rvalid, ram_en, ram_we, busy} !== 7'b0 ||
        ram_addr !== 31'h0 || ram_be !== 4'h0 || dm_rdata !== 32'h0 || if_rdata !== 32'h0) begin
      failures++;
      $display("FAIL abort_outputs got flags=%b addr=%h be=%h dm_rdata=%h if_rdata=%h required 0",
               {if_ack, if_rvalid, dm_ack, dm_rvalid, ram_en, ram_we, busy},
               ram_addr, ram_be, dm_rdata, if_rdata);
    end
    rst = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checks++;
      if (dm_rvalid !== 1'b0 || ram_en !== 1'b0) begin
        failures++;
        $display("FAIL abort_quiet cycle=%0d got dm_rvalid=%b ram_en=%b required 0 0", c, dm_rvalid, ram_en);
      end
    end
  endtask

  task automatic test_sample_hold;
    dm_req = 1; dm_we = 1; dm_addr = 31'h44; dm_be = 4'hF; dm_wdata = 32'h11112222;
    @(negedge clk);
    dm_req = 0; dm_addr = 31'h88; dm_wdata = 32'h33334444;
    #2;
    checks++;
    if (dm_ack !== 1'b1 || ram_addr !== 31'h44 || ram_wdata !== 32'h11112222) begin
      failures++;
      $display("FAIL sample_hold got dm_ack=%b addr=%h wdata=%h required 1 44 11112222",
               dm_ack, ram_addr, ram_wdata);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (mem_val(31'h44) !== 32'h11112222) begin
      failures++;
      $display("FAIL sample_mem got %h required 11112222", mem_val(31'h44));
    end
  endtask

  initial begin
    test_reset();
    test_fetch_read();
    test_store();
    test_back_to_back();
    test_starvation();
    test_streak_clear();
    test_reset_mid_cmd();
    test_sample_hold();
    repeat (5) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL pending_reads got %0d outstanding required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
